// File: rtl/float_types_pkg.sv
// float_types_pkg: shared single-precision number and result-status types
package float_types_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;

    typedef enum logic [1:0] {
        NORM_res = 2'b00,
        ZERO_res = 2'b01,
        INF_res  = 2'b10,
        NAN_res  = 2'b11
    } num_status_t;

endpackage

// File: rtl/fp_sum_result_collector_pkg.sv
// fp_sum_result_collector_pkg: FIFO entry layout for the summator result collector
package fp_sum_result_collector_pkg;

    import float_types_pkg::*;

    localparam int ENTRY_W = $bits(float_point_num) + $bits(num_status_t);

    typedef struct packed {
        float_point_num answer;
        num_status_t    status;
    } result_entry_t;

endpackage

// File: rtl/fp_sum_result_collector_fifo.sv
// fp_result_fifo: synchronous FIFO with a registered head word, one-cycle first-word latency
module fp_result_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 34
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic         do_push, do_pop;

    assign empty_o    = wr_ptr == rd_ptr;
    assign full_o     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(do_pop);

    // storage write; a full FIFO only accepts a word when the head leaves in the same cycle
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din_i;
    end

    // pointers and head register; the word landing on the next head slot bypasses storage
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout_o <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(do_push);
            rd_ptr <= rd_ptr_nxt;
            if (do_push && rd_ptr_nxt == wr_ptr) dout_o <= din_i;
            else if (rd_ptr_nxt != wr_ptr) dout_o <= mem[rd_ptr_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/fp_sum_result_collector.sv
// fp_sum_result_collector: re-aligns summator results to their issue tags, buffers them, tracks credit and stats
module fp_sum_result_collector
    import float_types_pkg::*;
    import fp_sum_result_collector_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           vld_i,
    input  float_point_num answer_i,
    input  num_status_t    num_status_i,
    output logic           issue_ok_o,
    output logic           vld_o,
    input  logic           ready_i,
    output float_point_num answer_o,
    output num_status_t    num_status_o,
    output logic           full_o,
    output logic           empty_o,
    output logic           drop_o,
    output logic [CNT_W-1:0] res_cnt_o,
    output logic [CNT_W-1:0] zero_cnt_o
);

    localparam int RW = $clog2(DEPTH + LATENCY) + 1;

    logic [LATENCY-1:0] tag;
    logic [RW-1:0]      reserve, reserve_nxt;
    logic [ENTRY_W-1:0] head_raw;
    result_entry_t      din, head;
    logic               wr_en, pop, wr_ok;

    assign wr_en        = tag[LATENCY-1];
    assign vld_o        = !empty_o;
    assign pop          = vld_o && ready_i;
    assign wr_ok        = wr_en && (!full_o || pop);
    assign din          = '{answer: answer_i, status: num_status_i};
    assign head         = result_entry_t'(head_raw);
    assign answer_o     = head.answer;
    assign num_status_o = head.status;
    assign issue_ok_o   = reserve < RW'(DEPTH);

    fp_result_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (wr_en),
        .pop_i   (pop),
        .din_i   (din),
        .dout_o  (head_raw),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

    // credit: one slot per issued request until its result is consumed, clamped at both ends
    always_comb begin
        reserve_nxt = (vld_i && !pop && reserve != '1) ? reserve + RW'(1) :
                      (pop && !vld_i && reserve != '0) ? reserve - RW'(1) : reserve;
    end

    // tag line, credit register, sticky drop and saturating statistics
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tag        <= '0;
            reserve    <= '0;
            drop_o     <= 1'b0;
            res_cnt_o  <= '0;
            zero_cnt_o <= '0;
        end else begin
            tag[0] <= vld_i;
            for (int k = 1; k < LATENCY; k++) tag[k] <= tag[k-1];
            reserve <= reserve_nxt;
            if (wr_en && full_o && !pop) drop_o <= 1'b1;
            if (wr_ok) begin
                res_cnt_o  <= res_cnt_o + CNT_W'(res_cnt_o != '1);
                zero_cnt_o <= zero_cnt_o + CNT_W'(num_status_i == ZERO_res && zero_cnt_o != '1);
            end
        end
    end

endmodule

// File: tb/tb_fp_sum_result_collector.sv
// tb_fp_sum_result_collector: directed scoreboard bench with a fixed-latency summator model
module tb_fp_sum_result_collector;

    import float_types_pkg::*;

    localparam int L  = 4;
    localparam int D  = 8;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst_i = 1'b0;
    logic           vld_i = 1'b0;
    logic           ready_i = 1'b1;
    float_point_num answer_i;
    num_status_t    num_status_i;
    logic           issue_ok_o, vld_o, full_o, empty_o, drop_o;
    float_point_num answer_o;
    num_status_t    num_status_o;
    logic [CW-1:0]  res_cnt_o, zero_cnt_o;

    logic [33:0] g_word = '0;
    logic [33:0] pipe [L];
    logic [33:0] exp_q [$];
    int          vecs = 0;
    int          errs = 0;

    logic [31:0] tab [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    always #5 clk = ~clk;

    fp_sum_result_collector #(.LATENCY(L), .DEPTH(D), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .vld_i        (vld_i),
        .answer_i     (answer_i),
        .num_status_i (num_status_i),
        .issue_ok_o   (issue_ok_o),
        .vld_o        (vld_o),
        .ready_i      (ready_i),
        .answer_o     (answer_o),
        .num_status_o (num_status_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .drop_o       (drop_o),
        .res_cnt_o    (res_cnt_o),
        .zero_cnt_o   (zero_cnt_o)
    );

    // summator stand-in: the golden word issued at edge t is on answer_i in the cycle before edge t+L
    always @(posedge clk) begin
        pipe[0] <= vld_i ? g_word : '0;
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign answer_i     = float_point_num'(pipe[L-1][33:2]);
    assign num_status_i = num_status_t'(pipe[L-1][1:0]);

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] want);
        vecs++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // monitor: every accepted head word must match the oldest expected result
    always @(negedge clk) begin
        if (rst_i && vld_o && ready_i) begin
            if (exp_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_output: got %h expected none", {answer_o, num_status_o});
            end else chk("fifo_head", {answer_o, num_status_o}, exp_q.pop_front());
        end
    end

    task automatic issue(input logic [31:0] a, input num_status_t s, input bit kept);
        g_word = {a, s};
        vld_i  = 1'b1;
        if (kept) exp_q.push_back({a, s});
        @(posedge clk);
        #1 vld_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        ready_i = 1'b1;
        while ((exp_q.size() != 0 || !empty_o) && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        chk("drain_done", 34'(exp_q.size() == 0 && empty_o), 34'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        chk("rst_flags", 34'({vld_o, empty_o, full_o, issue_ok_o, drop_o}), 34'b01010);
        chk("rst_cnts", 34'({res_cnt_o, zero_cnt_o}), 34'd0);
        chk("rst_head", {answer_o, num_status_o}, 34'd0);
        cycles(1);
        // 1.0 + 1.0
        issue(32'h40000000, NORM_res, 1'b1);
        drain(L + 4);
        chk("t1_res_cnt", 34'(res_cnt_o), 34'd1);
        // 0.875+2.2, 2+(-1), 0+0, inf+1, nan+1 back to back
        issue(32'h4044CCCD, NORM_res, 1'b1);
        issue(32'h3F800000, NORM_res, 1'b1);
        issue(32'h00000000, ZERO_res, 1'b1);
        issue(32'h7F800000, INF_res, 1'b1);
        issue(32'h7FC00000, NAN_res, 1'b1);
        drain(L + 10);
        chk("t2_res_cnt", 34'(res_cnt_o), 34'd6);
        chk("t2_zero_cnt", 34'(zero_cnt_o), 34'd1);
        // fill with ready low while honoring credit
        ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t3_ok_before", 34'(issue_ok_o), 34'd1);
            issue(tab[i], NORM_res, 1'b1);
        end
        chk("t3_ok_after8", 34'(issue_ok_o), 34'd0);
        cycles(L + 1);
        chk("t3_full_drop_empty", 34'({full_o, drop_o, empty_o}), 34'b100);
        chk("t3_head", {answer_o, num_status_o}, exp_q[0]);
        ready_i = 1'b1;
        cycles(1);
        ready_i = 1'b0;
        chk("t3_ok_after_pop", 34'(issue_ok_o), 34'd1);
        chk("t3_not_full", 34'(full_o), 34'd0);
        // refill, then write and pop together while full
        issue(32'h41200000, NORM_res, 1'b1);
        cycles(L + 1);
        chk("t5_full", 34'(full_o), 34'd1);
        chk("t5_no_credit", 34'(issue_ok_o), 34'd0);
        issue(32'h41300000, NORM_res, 1'b1);
        repeat (L - 1) @(posedge clk);
        #1 ready_i = 1'b1;
        cycles(1);
        ready_i = 1'b0;
        chk("t5_full_no_drop", 34'({full_o, drop_o}), 34'b10);
        // forced write into a full FIFO is discarded
        chk("t4_res_before", 34'(res_cnt_o), 34'd16);
        issue(32'h41400000, NORM_res, 1'b0);
        cycles(L + 1);
        chk("t4_drop_full", 34'({drop_o, full_o}), 34'b11);
        chk("t4_res_after", 34'(res_cnt_o), 34'd16);
        chk("t4_head", {answer_o, num_status_o}, exp_q[0]);
        drain(D + 12);
        chk("t4_drop_sticky", 34'(drop_o), 34'd1);
        // reset with two results in flight
        issue(32'h00000000, ZERO_res, 1'b1);
        issue(32'h00000000, ZERO_res, 1'b1);
        rst_i = 1'b0;
        cycles(1);
        rst_i = 1'b1;
        exp_q.delete();
        cycles(L + 3);
        chk("t6_flags", 34'({vld_o, empty_o, full_o, issue_ok_o, drop_o}), 34'b01010);
        chk("t6_cnts", 34'({res_cnt_o, zero_cnt_o}), 34'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
